emif_calbus_master: RTL and testbench

- Parametrised calibration-bus master for one or more EMIF instances.
- Accepts single read, write or poll-until-match requests over a valid/ready port and issues one-cycle calbus_read/calbus_write strobes to the selected channel.
- Captures read data after a fixed read latency and returns a response with a status code.
- Sits between the UART-TL bringup register bridge and the emif calbus ports of the memory subsystem, giving software access to EMIF calibration registers.

---
 rtl/emif_calbus_pkg.sv | 33 +++
 rtl/calbus_chan_mux.sv | 31 +++
 rtl/emif_calbus_master.sv | 178 +++++++++++++++++
 tb/tb_emif_calbus_master.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emif_calbus_pkg.sv
// Shared types and constants for the EMIF calibration-bus master.
// Opcodes, status codes, FSM states and a channel-index width helper.
package emif_calbus_pkg;

   localparam int OP_W     = 2;
   localparam int STATUS_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_POLL  = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   typedef enum logic [STATUS_W-1:0] {
      ST_OK      = 2'b00,
      ST_TIMEOUT = 2'b01,
      ST_BADREQ  = 2'b10
   } status_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_GAP,
      S_RESP
   } state_e;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/calbus_chan_mux.sv
// Channel fan-out/fan-in: turns chan plus strobe enables into one-hot strobes
// and selects the addressed channel's read-data slice.
module calbus_chan_mux #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 32,
   parameter int CH_W   = 1
) (
   input  logic [CH_W-1:0]          chan,
   input  logic                     rd_en,
   input  logic                     wr_en,
   input  logic [NUM_CH*DATA_W-1:0] calbus_rdata,
   output logic [NUM_CH-1:0]        calbus_read,
   output logic [NUM_CH-1:0]        calbus_write,
   output logic [DATA_W-1:0]        rdata
);

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_strobe
         assign calbus_read[gi]  = rd_en && (chan == CH_W'(gi));
         assign calbus_write[gi] = wr_en && (chan == CH_W'(gi));
      end
   endgenerate

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (chan == CH_W'(i)) rdata = calbus_rdata[i*DATA_W +: DATA_W];
      end
   end

endmodule

// File: rtl/emif_calbus_master.sv
// Calibration-bus master: one read/write/poll request in flight at a time,
// issuing single-cycle strobes and returning data plus status.
module emif_calbus_master
   import emif_calbus_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int ADDR_W   = 20,
   parameter int DATA_W   = 32,
   parameter int RD_LAT   = 2,
   parameter int POLL_MAX = 1024,
   parameter int POLL_GAP = 8,
   localparam int CH_W    = ch_width(NUM_CH)
) (
   input  logic                     clk_clk,
   input  logic                     reset_reset_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_op,
   input  logic [CH_W-1:0]          req_chan,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic [DATA_W-1:0]        req_wdata,
   input  logic [DATA_W-1:0]        req_mask,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic [1:0]               rsp_status,
   output logic [NUM_CH-1:0]        calbus_read,
   output logic [NUM_CH-1:0]        calbus_write,
   output logic [ADDR_W-1:0]        calbus_address,
   output logic [DATA_W-1:0]        calbus_wdata,
   input  logic [NUM_CH*DATA_W-1:0] calbus_rdata
);

   localparam int CNT_MAX = (RD_LAT > POLL_GAP) ? RD_LAT : POLL_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int PC_W    = $clog2(POLL_MAX + 1);

   state_e              state_reg, state_next;
   op_e                 op_reg;
   status_e             status_reg, status_next;
   logic                ready_reg;
   logic [CH_W-1:0]     chan_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   wdata_reg, mask_reg;
   logic [DATA_W-1:0]   rdata_reg, rdata_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [PC_W-1:0]     poll_reg, poll_next;
   logic                accept, rd_en, wr_en;
   logic [DATA_W-1:0]   sel_rdata;

   // Lookup of legal channel indices over the full range of req_chan.
   logic [(1<<CH_W)-1:0] chan_ok;
   generate
      for (genvar gi = 0; gi < (1 << CH_W); gi++) begin : g_chan_ok
         assign chan_ok[gi] = (gi < NUM_CH);
      end
   endgenerate

   calbus_chan_mux #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .CH_W   (CH_W)
   ) u_mux (
      .chan         (chan_reg),
      .rd_en        (rd_en),
      .wr_en        (wr_en),
      .calbus_rdata (calbus_rdata),
      .calbus_read  (calbus_read),
      .calbus_write (calbus_write),
      .rdata        (sel_rdata)
   );

   always_comb begin
      state_next  = state_reg;
      status_next = status_reg;
      rdata_next  = rdata_reg;
      cnt_next    = cnt_reg;
      poll_next   = poll_reg;
      accept      = 1'b0;
      rd_en       = 1'b0;
      wr_en       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (req_valid && ready_reg) begin
               accept    = 1'b1;
               poll_next = '0;
               if (op_e'(req_op) == OP_RSVD || !chan_ok[req_chan]) begin
                  state_next  = S_RESP;
                  status_next = ST_BADREQ;
                  rdata_next  = '0;
               end else begin
                  state_next = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (op_reg == OP_WRITE) begin
               wr_en       = 1'b1;
               state_next  = S_RESP;
               status_next = ST_OK;
               rdata_next  = '0;
            end else begin
               rd_en      = 1'b1;
               cnt_next   = CNT_W'(RD_LAT);
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_next = cnt_reg - 1'b1;
            // Counter at 1 marks the cycle the addressed channel's data is valid.
            if (cnt_reg == CNT_W'(1)) begin
               rdata_next = sel_rdata;
               if (op_reg == OP_READ || ((sel_rdata ^ wdata_reg) & mask_reg) == '0) begin
                  state_next  = S_RESP;
                  status_next = ST_OK;
               end else begin
                  poll_next = poll_reg + 1'b1;
                  if (poll_next == PC_W'(POLL_MAX)) begin
                     state_next  = S_RESP;
                     status_next = ST_TIMEOUT;
                  end else if (POLL_GAP == 0) begin
                     state_next = S_ISSUE;
                  end else begin
                     cnt_next   = CNT_W'(POLL_GAP);
                     state_next = S_GAP;
                  end
               end
            end
         end
         S_GAP: begin
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == CNT_W'(1)) state_next = S_ISSUE;
         end
         S_RESP: begin
            if (rsp_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_reg  <= S_IDLE;
         status_reg <= ST_OK;
         ready_reg  <= 1'b0;
         op_reg     <= OP_READ;
         chan_reg   <= '0;
         addr_reg   <= '0;
         wdata_reg  <= '0;
         mask_reg   <= '0;
         rdata_reg  <= '0;
         cnt_reg    <= '0;
         poll_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         status_reg <= status_next;
         ready_reg  <= (state_next == S_IDLE);
         rdata_reg  <= rdata_next;
         cnt_reg    <= cnt_next;
         poll_reg   <= poll_next;
         if (accept) begin
            op_reg    <= op_e'(req_op);
            chan_reg  <= req_chan;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            mask_reg  <= req_mask;
         end
      end
   end

   assign req_ready      = ready_reg;
   assign rsp_valid      = (state_reg == S_RESP);
   assign rsp_rdata      = rdata_reg;
   assign rsp_status     = status_reg;
   assign calbus_address = addr_reg;
   assign calbus_wdata   = wdata_reg;

endmodule

// File: tb/tb_emif_calbus_master.sv
// Directed bench for emif_calbus_master: a calbus slave model, a schedule-based
// reference model checked every cycle, and literal checks per transaction.
module tb_emif_calbus_master;

   localparam int NUM_CH   = 3;
   localparam int ADDR_W   = 20;
   localparam int DATA_W   = 32;
   localparam int RD_LAT   = 2;
   localparam int POLL_MAX = 4;
   localparam int POLL_GAP = 3;
   localparam int CH_W     = 2;

   logic                     clk = 1'b0;
   logic                     reset_reset_n = 1'b0;
   logic                     req_valid = 1'b0;
   logic                     req_ready;
   logic [1:0]               req_op = '0;
   logic [CH_W-1:0]          req_chan = '0;
   logic [ADDR_W-1:0]        req_addr = '0;
   logic [DATA_W-1:0]        req_wdata = '0;
   logic [DATA_W-1:0]        req_mask = '0;
   logic                     rsp_valid;
   logic                     rsp_ready = 1'b1;
   logic [DATA_W-1:0]        rsp_rdata;
   logic [1:0]               rsp_status;
   logic [NUM_CH-1:0]        calbus_read, calbus_write;
   logic [ADDR_W-1:0]        calbus_address;
   logic [DATA_W-1:0]        calbus_wdata;
   logic [NUM_CH*DATA_W-1:0] calbus_rdata = '0;

   always #5 clk = ~clk;

   emif_calbus_master #(
      .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .RD_LAT(RD_LAT), .POLL_MAX(POLL_MAX), .POLL_GAP(POLL_GAP)
   ) dut (
      .clk_clk(clk), .reset_reset_n(reset_reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_chan(req_chan), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_mask(req_mask), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
      .calbus_read(calbus_read), .calbus_write(calbus_write),
      .calbus_address(calbus_address), .calbus_wdata(calbus_wdata),
      .calbus_rdata(calbus_rdata)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Calbus slave: a read strobe seen in cycle S returns the next queued value
   // only during cycle S+RD_LAT; every other cycle carries junk with bit0 clear.
   logic [DATA_W-1:0] rd_vals[$];
   int                due[NUM_CH] = '{default: -1};
   logic [DATA_W-1:0] due_val[NUM_CH] = '{default: '0};

   initial forever begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) begin
         if (!reset_reset_n) due[c] = -1;
         else if (calbus_read[c]) begin
            due[c]     = cyc + RD_LAT;
            due_val[c] = (rd_vals.size() > 0) ? rd_vals.pop_front() : '0;
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++)
         calbus_rdata[c*DATA_W +: DATA_W] = (cyc == due[c]) ? due_val[c]
                                            : (32'hBAD0_0000 ^ (32'(cyc) << 4));
   end

   // Reference model: on accept, compute the full schedule of strobes and the
   // response from the request and the values the slave will return.
   logic [NUM_CH-1:0] exp_rd_at[int];
   logic [NUM_CH-1:0] exp_wr_at[int];
   bit                busy = 1'b0;
   bit                was_up = 1'b0;
   int                exp_rsp_cyc;
   logic [DATA_W-1:0] exp_rdata;
   logic [1:0]        exp_status;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_wdata;

   int                obs_t0, obs_rsp_cyc;
   int                obs_strobes[$];
   bit                rsp_seen;
   logic [DATA_W-1:0] obs_rdata;
   logic [1:0]        obs_status;
   logic [NUM_CH-1:0] obs_rd_vec, obs_wr_vec;

   task automatic model_accept();
      logic [DATA_W-1:0] d;
      logic [NUM_CH-1:0] oh;
      int                s, k;
      bit                done;
      exp_rd_at.delete();
      exp_wr_at.delete();
      obs_strobes.delete();
      rsp_seen  = 1'b0;
      busy      = 1'b1;
      obs_t0    = cyc;
      exp_addr  = req_addr;
      exp_wdata = req_wdata;
      oh        = '0;
      if (req_op == 2'b11 || int'(req_chan) >= NUM_CH) begin
         exp_rsp_cyc = cyc + 1;
         exp_status  = 2'b10;
         exp_rdata   = '0;
      end else begin
         oh[req_chan] = 1'b1;
         if (req_op == 2'b01) begin
            exp_wr_at[cyc+1] = oh;
            exp_rsp_cyc      = cyc + 2;
            exp_status       = 2'b00;
            exp_rdata        = '0;
         end else begin
            k    = 0;
            done = 1'b0;
            while (!done) begin
               s            = cyc + 1 + k * (RD_LAT + 1 + POLL_GAP);
               exp_rd_at[s] = oh;
               d            = (k < rd_vals.size()) ? rd_vals[k] : '0;
               exp_rdata    = d;
               exp_rsp_cyc  = s + RD_LAT + 1;
               if (req_op == 2'b00 || ((d ^ req_wdata) & req_mask) == '0) begin
                  exp_status = 2'b00;
                  done       = 1'b1;
               end else if (k + 1 == POLL_MAX) begin
                  exp_status = 2'b01;
                  done       = 1'b1;
               end
               k++;
            end
         end
      end
   endtask

   initial forever begin
      logic [NUM_CH-1:0] erd, ewr;
      bit                ev;
      @(negedge clk);
      if (!reset_reset_n) begin
         chk("reset_outs_zero", |{req_ready, rsp_valid, rsp_rdata, rsp_status, calbus_read,
                                  calbus_write, calbus_address, calbus_wdata}, 1'b0);
         busy   = 1'b0;
         was_up = 1'b0;
         exp_rd_at.delete();
         exp_wr_at.delete();
      end else begin
         erd = exp_rd_at.exists(cyc) ? exp_rd_at[cyc] : '0;
         ewr = exp_wr_at.exists(cyc) ? exp_wr_at[cyc] : '0;
         chk("strobes", {calbus_read, calbus_write}, {erd, ewr});
         if (calbus_read != '0 || calbus_write != '0) begin
            if (obs_strobes.size() == 0) begin
               obs_rd_vec = calbus_read;
               obs_wr_vec = calbus_write;
            end
            obs_strobes.push_back(cyc);
         end
         ev = busy && (cyc >= exp_rsp_cyc);
         chk("rsp_valid", rsp_valid, ev);
         if (busy) begin
            chk("req_ready_busy", req_ready, 1'b0);
            chk("calbus_address", calbus_address, exp_addr);
            chk("calbus_wdata", calbus_wdata, exp_wdata);
         end else if (was_up) begin
            chk("req_ready_idle", req_ready, 1'b1);
         end
         if (rsp_valid && ev) begin
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_status", rsp_status, exp_status);
            if (!rsp_seen) begin
               rsp_seen    = 1'b1;
               obs_rsp_cyc = cyc;
               obs_rdata   = rsp_rdata;
               obs_status  = rsp_status;
            end
         end
         if (busy && rsp_valid && rsp_ready) busy = 1'b0;
         else if (!busy && req_valid && req_ready) model_accept();
         was_up = 1'b1;
      end
   end

   task automatic send(input logic [1:0] op, input logic [CH_W-1:0] ch,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                       input logic [DATA_W-1:0] mask);
      bit ok;
      @(posedge clk);
      #1;
      req_op = op; req_chan = ch; req_addr = addr; req_wdata = wd; req_mask = mask;
      req_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("req_accepted", ok, 1'b1);
   endtask

   task automatic wait_rsp(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      chk("rsp_arrived", ok, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      #2 reset_reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Write to channel 1
      rsp_ready = 1'b1;
      send(2'b01, 2'd1, 20'h00123, 32'hDEADBEEF, 32'h0);
      wait_rsp(20);
      chk("wr_latency", obs_rsp_cyc - obs_t0, 2);
      chk("wr_strobe_count", obs_strobes.size(), 1);
      chk("wr_strobe_vec", {obs_rd_vec, obs_wr_vec}, {3'b000, 3'b010});
      chk("wr_status", obs_status, 2'b00);
      chk("wr_rdata", obs_rdata, 32'h0);

      // Single read from channel 0
      rd_vals.delete();
      rd_vals.push_back(32'hA5A5_0001);
      send(2'b00, 2'd0, 20'h00040, 32'h0, 32'h0);
      wait_rsp(20);
      chk("rd_latency", obs_rsp_cyc - obs_t0, 4);
      chk("rd_strobe_vec", {obs_rd_vec, obs_wr_vec}, {3'b001, 3'b000});
      chk("rd_rdata", obs_rdata, 32'hA5A5_0001);
      chk("rd_status", obs_status, 2'b00);

      // Poll that matches on the fourth read
      rd_vals.delete();
      rd_vals = '{32'h0, 32'h0, 32'h0, 32'h1};
      send(2'b10, 2'd1, 20'h00200, 32'h1, 32'h1);
      wait_rsp(80);
      chk("poll_strobe_count", obs_strobes.size(), 4);
      if (obs_strobes.size() == 4) begin
         chk("poll_spacing_1", obs_strobes[1] - obs_strobes[0], 6);
         chk("poll_spacing_3", obs_strobes[3] - obs_strobes[0], 18);
         chk("poll_rsp_after_last", obs_rsp_cyc - obs_strobes[3], 3);
      end
      chk("poll_status", obs_status, 2'b00);
      chk("poll_rdata", obs_rdata, 32'h1);

      // Poll that never matches
      rd_vals = '{32'h11, 32'h22, 32'h33, 32'h44};
      send(2'b10, 2'd0, 20'h00300, 32'h5A, 32'hFF);
      wait_rsp(80);
      chk("tmo_strobe_count", obs_strobes.size(), 4);
      chk("tmo_status", obs_status, 2'b01);
      chk("tmo_rdata", obs_rdata, 32'h44);

      // Bad channel with a stalled response, then reserved opcode
      rsp_ready = 1'b0;
      send(2'b00, 2'd3, 20'h00400, 32'h0, 32'h0);
      repeat (5) @(negedge clk);
      chk("bad_hold_valid", rsp_valid, 1'b1);
      chk("bad_hold_ready", req_ready, 1'b0);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      wait_rsp(20);
      chk("bad_chan_latency", obs_rsp_cyc - obs_t0, 1);
      chk("bad_chan_status", obs_status, 2'b10);
      chk("bad_chan_strobes", obs_strobes.size(), 0);
      send(2'b11, 2'd0, 20'h00500, 32'h0, 32'h0);
      wait_rsp(20);
      chk("rsvd_status", obs_status, 2'b10);
      chk("rsvd_strobes", obs_strobes.size(), 0);

      // Reset while a poll is waiting for read data
      rd_vals = '{32'h0, 32'h0, 32'h0, 32'h0};
      send(2'b10, 2'd1, 20'h00600, 32'h1, 32'h1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (calbus_read != '0) break;
      end
      @(negedge clk);
      #2 reset_reset_n = 1'b0;
      #1 chk("async_reset_outs", |{req_ready, rsp_valid, rsp_rdata, rsp_status, calbus_read,
                                   calbus_write, calbus_address, calbus_wdata}, 1'b0);
      repeat (3) @(negedge clk);
      #2 reset_reset_n = 1'b1;
      rd_vals.delete();
      rd_vals.push_back(32'h1234_5678);
      repeat (2) @(negedge clk);
      send(2'b00, 2'd2, 20'h00700, 32'h0, 32'h0);
      wait_rsp(20);
      chk("post_reset_latency", obs_rsp_cyc - obs_t0, 4);
      chk("post_reset_vec", obs_rd_vec, 3'b100);
      chk("post_reset_rdata", obs_rdata, 32'h1234_5678);
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
